// File: rtl/gpio_seq_pkg.sv
// Shared types and defaults for the GPIO serial-chain configuration sequencer.
// Optional pre-programming chain reset is enabled by GPIO_SEQ_SERIAL_RESET_EN.
package gpio_seq_pkg;

  localparam int NUM_PADS_DEF  = 19;
  localparam int CFG_WIDTH_DEF = 10;
  localparam int CLK_DIV_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRERESET,
    ST_FETCH,
    ST_SHIFT,
    ST_LOAD,
    ST_FINISH
  } seq_state_t;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/gpio_seq_clkdiv.sv
// Phase divider: phase_tick every CLK_DIV enabled cycles; serial_clock toggles on a tick
// only when toggle_en is set. Disabling clears the phase so every enable starts on a low phase.
module gpio_seq_clkdiv
  import gpio_seq_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic wb_clk_i,
  input  logic resetb,
  input  logic en,
  input  logic toggle_en,
  output logic phase_tick,
  output logic serial_clock
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign phase_tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      div_cnt      <= '0;
      serial_clock <= 1'b0;
    end else if (!en) begin
      div_cnt      <= '0;
      serial_clock <= 1'b0;
    end else begin
      div_cnt <= phase_tick ? '0 : div_cnt + DIV_W'(1);
      if (phase_tick && toggle_en) serial_clock <= ~serial_clock;
    end
  end

endmodule

// File: rtl/gpio_config_sequencer.sv
// Fetches one config word per pad and shifts them MSB-first down the GPIO chain, then
// pulses serial_load. GPIO_SEQ_SERIAL_RESET_EN adds a chain reset phase before the first fetch.
module gpio_config_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int NUM_PADS  = NUM_PADS_DEF,
  parameter int CFG_WIDTH = CFG_WIDTH_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input  logic                           wb_clk_i,
  input  logic                           resetb,
  input  logic                           start,
  output logic                           word_req,
  output logic [idx_width(NUM_PADS)-1:0] word_idx,
  input  logic                           word_valid,
  input  logic [CFG_WIDTH-1:0]           word_data,
  output logic                           serial_clock,
  output logic                           serial_data,
  output logic                           serial_load,
  output logic                           serial_resetn,
  output logic                           busy,
  output logic                           done
);

  localparam int IDX_W = idx_width(NUM_PADS);
  localparam int BIT_W = $clog2(CFG_WIDTH + 1);
  localparam logic [IDX_W-1:0] PAD_LAST = IDX_W'(NUM_PADS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_WIDTH - 1);

  seq_state_t state, state_nxt;

  logic [IDX_W-1:0]     pad_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CFG_WIDTH-1:0] shreg;
  logic                 div_en;
  logic                 phase_tick;
  logic                 bit_fall;
  logic                 last_bit;

  assign div_en   = (state == ST_SHIFT) || (state == ST_LOAD) || (state == ST_PRERESET);
  assign bit_fall = (state == ST_SHIFT) && phase_tick && serial_clock;
  assign last_bit = (bit_cnt == BIT_LAST);

  gpio_seq_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .wb_clk_i    (wb_clk_i),
    .resetb      (resetb),
    .en          (div_en),
    .toggle_en   (state == ST_SHIFT),
    .phase_tick  (phase_tick),
    .serial_clock(serial_clock)
  );

`ifdef GPIO_SEQ_SERIAL_RESET_EN
  // Ticks spent in PRERESET: 0,1 hold the chain in reset, 2 is the recovery phase.
  logic [1:0] pre_cnt;

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb)                 pre_cnt <= '0;
    else if (state != ST_PRERESET) pre_cnt <= '0;
    else if (phase_tick)         pre_cnt <= pre_cnt + 2'd1;
  end
`endif

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
`ifdef GPIO_SEQ_SERIAL_RESET_EN
        if (start) state_nxt = ST_PRERESET;
`else
        if (start) state_nxt = ST_FETCH;
`endif
      end
`ifdef GPIO_SEQ_SERIAL_RESET_EN
      ST_PRERESET: if (phase_tick && (pre_cnt == 2'd2)) state_nxt = ST_FETCH;
`endif
      ST_FETCH:  if (word_valid) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (bit_fall && last_bit) state_nxt = (pad_cnt == '0) ? ST_LOAD : ST_FETCH;
      ST_LOAD:   if (phase_tick) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Data is shifted on the falling edge so serial_data only moves while serial_clock is low.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      pad_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) pad_cnt <= PAD_LAST;
        ST_FETCH: begin
          if (word_valid) begin
            shreg   <= word_data;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (bit_fall) begin
            shreg <= shreg << 1;
            if (last_bit) begin
              bit_cnt <= '0;
              if (pad_cnt != '0) pad_cnt <= pad_cnt - IDX_W'(1);
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word_req      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    serial_load   = 1'b0;
    serial_resetn = 1'b1;
    case (state)
`ifdef GPIO_SEQ_SERIAL_RESET_EN
      ST_PRERESET: begin
        busy          = 1'b1;
        serial_resetn = pre_cnt[1];
      end
`endif
      ST_FETCH: begin
        busy     = 1'b1;
        word_req = 1'b1;
      end
      ST_SHIFT: busy = 1'b1;
      ST_LOAD: begin
        busy        = 1'b1;
        serial_load = 1'b1;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign word_idx    = pad_cnt;
  assign serial_data = shreg[CFG_WIDTH-1];

endmodule

// File: tb/tb_gpio_config_sequencer.sv
// Bench for gpio_config_sequencer: table of word sets plus hand-written corner sequences,
// bitstream checked against the pad-ordered concatenation of the supplied words.
module tb_gpio_config_sequencer;

  localparam int NP = 3;
  localparam int CW = 10;
  localparam int CD = 2;

  logic clk;
  logic resetb;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: 3 pads, 10 bits, CLK_DIV=2
  logic          start, word_req, word_valid;
  logic [1:0]    word_idx;
  logic [CW-1:0] word_data;
  logic          serial_clock, serial_data, serial_load, serial_resetn, busy, done;

  gpio_config_sequencer #(.NUM_PADS(NP), .CFG_WIDTH(CW), .CLK_DIV(CD)) dut (
    .wb_clk_i(clk), .resetb(resetb), .start(start),
    .word_req(word_req), .word_idx(word_idx), .word_valid(word_valid), .word_data(word_data),
    .serial_clock(serial_clock), .serial_data(serial_data), .serial_load(serial_load),
    .serial_resetn(serial_resetn), .busy(busy), .done(done)
  );

  // Second DUT: 1 pad, CLK_DIV=1
  logic          start2, word_req2, word_valid2;
  logic [0:0]    word_idx2;
  logic [CW-1:0] word_data2;
  logic          serial_clock2, serial_data2, serial_load2, serial_resetn2, busy2, done2;

  gpio_config_sequencer #(.NUM_PADS(1), .CFG_WIDTH(CW), .CLK_DIV(1)) dut2 (
    .wb_clk_i(clk), .resetb(resetb), .start(start2),
    .word_req(word_req2), .word_idx(word_idx2), .word_valid(word_valid2), .word_data(word_data2),
    .serial_clock(serial_clock2), .serial_data(serial_data2), .serial_load(serial_load2),
    .serial_resetn(serial_resetn2), .busy(busy2), .done(done2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester model: answers each word_req after a per-pad delay
  logic [NP-1:0][CW-1:0] cur_words;
  logic [NP-1:0][7:0]    cur_delay;
  int                    idx_log[$];
  int                    wait_cnt;

  initial begin
    word_valid = 1'b0;
    word_data  = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        word_valid = 1'b0;
        wait_cnt   = 0;
      end else if (word_valid) begin
        word_valid = 1'b0;
      end else if (word_req) begin
        if (wait_cnt >= int'(cur_delay[word_idx])) begin
          word_valid = 1'b1;
          word_data  = cur_words[word_idx];
          idx_log.push_back(int'(word_idx));
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Chain observer: captures data on serial_clock rises and flags protocol breaches
  logic rec_bits[$];
  int   rises, load_cycles, done_cnt, proto_err;
  logic prev_sclk, prev_sdata;

  initial begin
    prev_sclk = 1'b0;
    prev_sdata = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        prev_sclk = 1'b0;
      end else begin
        if (serial_clock && !prev_sclk) begin
          rec_bits.push_back(serial_data);
          rises++;
        end
        if (serial_clock && prev_sclk && (serial_data !== prev_sdata)) proto_err++;
        if (word_req && serial_clock) proto_err++;
        if (serial_load) begin
          load_cycles++;
          if (serial_clock) proto_err++;
        end
        if (done) begin
          done_cnt++;
          if (busy) proto_err++;
        end
        prev_sclk  = serial_clock;
        prev_sdata = serial_data;
      end
    end
  end

  typedef struct {
    logic [NP-1:0][CW-1:0] w;
    logic [NP-1:0][7:0]    dly;
    bit                    poke;
    int                    exp_rises;
    int                    exp_load;
    int                    exp_done;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [8:0] out_vec();
    return {serial_clock, serial_data, serial_load, serial_resetn, word_req, word_idx, busy, done};
  endfunction

  localparam logic [8:0] RESET_OUTS = 9'b0_0_0_1_0_00_0_0;

  task automatic clear_obs(input vec_t v);
    rec_bits.delete();
    idx_log.delete();
    rises = 0; load_cycles = 0; done_cnt = 0; proto_err = 0;
    cur_words = v.w;
    cur_delay = v.dly;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc = 0, tail = 0;
    bit seen = 0, poked = 0;
    logic [63:0] act_stream = '0;
    clear_obs(v);
    @(negedge clk); start = 1'b1;
    while (cyc < 3000 && tail < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (v.poke && !poked && rises >= 5) begin
        start = 1'b1;
        poked = 1;
      end
      if (done && !seen) begin
        seen = 1;
        if (v.poke) start = 1'b1;
      end
      if (seen) tail++;
    end
    start = 1'b0;
    foreach (rec_bits[i]) act_stream = {act_stream[62:0], rec_bits[i]};
    check($sformatf("v%0d_done_seen", id), 64'(seen), 64'd1);
    check($sformatf("v%0d_rises", id), 64'(rises), 64'(v.exp_rises));
    // Expected chain order: pad NP-1 first, each word MSB first
    check($sformatf("v%0d_bitstream", id), act_stream, 64'(v.w));
    check($sformatf("v%0d_load_cycles", id), 64'(load_cycles), 64'(v.exp_load));
    check($sformatf("v%0d_done_pulses", id), 64'(done_cnt), 64'(v.exp_done));
    check($sformatf("v%0d_idx_seq", id),
          64'((idx_log.size() == 3) ? idx_log[0] * 100 + idx_log[1] * 10 + idx_log[2] : -1), 64'd210);
    check($sformatf("v%0d_protocol", id), 64'(proto_err), 64'd0);
    check($sformatf("v%0d_idle_after", id), {62'd0, busy, word_req}, 64'd0);
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    if (!done) check(name, 64'd0, 64'd1);
  endtask

  initial begin
    int lat, rl, cyc, last_rise, done_t, bad_gap, load2, n2;
    logic [63:0] stream2;
    start = 1'b0; start2 = 1'b0; word_valid2 = 1'b0; word_data2 = '0;
    rises = 0; load_cycles = 0; done_cnt = 0; proto_err = 0;
    cur_words = '0; cur_delay = '0;

    for (int i = 0; i < 6; i++) begin
      tbl[i].w         = {10'h007, 10'h3FF, 10'h000};
      tbl[i].dly       = '0;
      tbl[i].poke      = 0;
      tbl[i].exp_rises = NP * CW;
      tbl[i].exp_load  = CD;
      tbl[i].exp_done  = 1;
    end
    tbl[1].dly  = {8'd0, 8'd7, 8'd0};
    tbl[2].poke = 1;
    for (int i = 3; i < 6; i++) begin
      for (int p = 0; p < NP; p++) begin
        tbl[i].w[p]   = 10'($urandom);
        tbl[i].dly[p] = 8'($urandom_range(0, 3));
      end
    end

    resetb = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(out_vec()), 64'(RESET_OUTS));
    resetb = 1'b1;
    @(negedge clk);

    // Start-to-first-request latency and chain reset pulse
    clear_obs(tbl[0]);
    start = 1'b1;
    lat = 0; rl = 0;
    while (lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (!serial_resetn) rl++;
      if (word_req) break;
    end
`ifdef GPIO_SEQ_SERIAL_RESET_EN
    check("req_latency", 64'(lat), 64'(1 + 3 * CD));
    check("resetn_low_cycles", 64'(rl), 64'(2 * CD));
`else
    check("req_latency", 64'(lat), 64'd1);
    check("resetn_low_cycles", 64'(rl), 64'd0);
`endif
    wait_done("latency_seq_done");
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Async abort during the 5th bit of pad 1
    clear_obs(tbl[0]);
    start = 1'b1;
    cyc = 0;
    @(negedge clk); start = 1'b0;
    while (rises < CW + 5 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_bit", 64'(rises >= CW + 5), 64'd1);
    #2 resetb = 1'b0;
    #1 check("abort_async_outputs", 64'(out_vec()), 64'(RESET_OUTS));
    repeat (3) @(negedge clk);
    check("abort_no_load", 64'(load_cycles), 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_held_outputs", 64'(out_vec()), 64'(RESET_OUTS));
    resetb = 1'b1;
    @(negedge clk);
    run_vec(tbl[0], 10);

    // Start in the cycle right after done launches a new sequence
    clear_obs(tbl[0]);
    start = 1'b1;
    @(negedge clk);
    wait_done("b2b_first_done");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("b2b_restart_busy", 64'(busy), 64'd1);
    wait_done("b2b_second_done");
    repeat (3) @(negedge clk);

    // Single pad, CLK_DIV=1, alternating pattern
    stream2 = '0; n2 = 0; last_rise = -10; done_t = -1; bad_gap = 0; load2 = 0;
    word_data2 = 10'h2AA;
    start2 = 1'b1;
    cyc = 0;
    begin
      logic p2 = 1'b0;
      while (cyc < 300 && done_t < 0) begin
        @(negedge clk);
        cyc++;
        start2 = 1'b0;
        word_valid2 = word_req2 && !word_valid2;
        if (serial_clock2 && !p2) begin
          stream2 = {stream2[62:0], serial_data2};
          if (n2 > 0 && cyc - last_rise != 2) bad_gap++;
          last_rise = cyc;
          n2++;
        end
        if (serial_load2) load2++;
        if (done2) done_t = cyc;
        p2 = serial_clock2;
      end
    end
    word_valid2 = 1'b0;
    check("p1_rises", 64'(n2), 64'd10);
    check("p1_bitstream", stream2, 64'h2AA);
    check("p1_bit_period", 64'(bad_gap), 64'd0);
    check("p1_load_cycles", 64'(load2), 64'd1);
    check("p1_done_after_last_rise", 64'(done_t - last_rise), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
